// File: rtl/display_input_scanner_pkg.sv
// Shared types and constants for the display board input scanner.
// Register map, STATUS bit positions and the scan FSM encoding live here.
package display_input_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SAMPLE = 2'd1,
    CLK_HI = 2'd2,
    COMMIT = 2'd3
  } scan_state_t;

  localparam logic [1:0] REG_BUTTONS = 2'd0;
  localparam logic [1:0] REG_DIAL_L  = 2'd1;
  localparam logic [1:0] REG_DIAL_R  = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int STATUS_CHANGED = 0;
  localparam int STATUS_IRQ_EN  = 1;
  localparam int STATUS_CNT_LSB = 16;

  // Gray {A,B} to position 0..3 so a step is a +/-1 difference mod 4.
  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/display_input_scanner_if.sv
// Avalon-MM slave bus between the HPS bridge and the input scanner.
interface display_input_scanner_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (output avs_address, avs_read, avs_write, avs_writedata,
                  input  avs_readdata);
  modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                  output avs_readdata);
endinterface

// File: rtl/display_input_scanner_quad_decoder.sv
// One rotary dial: 2-flop synchroniser, previous-state register and an
// 8-bit wrapping position counter that a bus write can overwrite.
module quad_decoder
  import display_input_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] ab_i,
  input  logic       load_i,
  input  logic [7:0] load_value_i,
  output logic [7:0] count_o
);

  logic [1:0] sync1_q, sync2_q, prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] delta;

  always_comb begin
    delta = gray2bin(sync2_q) - gray2bin(prev_q);
    cnt_d = cnt_q;
    // A load takes priority; a step in the same cycle is dropped.
    if (load_i)             cnt_d = load_value_i;
    else if (delta == 2'd1) cnt_d = cnt_q + 8'd1;
    else if (delta == 2'd3) cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ab_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/display_input_scanner.sv
// Scans the button shift register, debounces over two scans, decodes both
// rotary dials and exposes everything through an Avalon-MM slave with irq.
module display_input_scanner
  import display_input_pkg::*;
#(
  parameter int CLK_DIV  = 25,
  parameter int NUM_BITS = 8
)(
  input  logic                    clk,
  input  logic                    reset_n,
  display_input_scanner_if.slave  avs,
  output logic                    irq,
  output logic                    shift_clkin,
  output logic                    shift_load,
  input  logic                    shift_out,
  input  logic [1:0]              dial_l,
  input  logic [1:0]              dial_r
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(NUM_BITS + 1);

  scan_state_t         state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [NUM_BITS-1:0] shreg_q, shreg_d, prev_q, buttons_q;
  logic                changed_q, changed_d, irq_en_q, irq_en_d, irq_q;
  logic [15:0]         scan_cnt_q;
  logic [31:0]         readdata_q, rdata;
  logic                shift_load_q, shift_clkin_q;
  logic                tick, commit, commit_set, rd_buttons, wr_status;
  logic                ld_l, ld_r;
  logic [7:0]          cnt_l, cnt_r;
  logic                unused_wdata;

  assign tick = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    commit    = 1'b0;
    // The divider idles during COMMIT so every LOAD gets a full tick.
    if (state_q == COMMIT || tick) div_d = '0;
    else                           div_d = div_q + 1'b1;
    case (state_q)
      LOAD: begin
        bit_cnt_d = '0;
        if (tick) state_d = SAMPLE;
      end
      SAMPLE: if (tick) begin
        state_d   = CLK_HI;
        shreg_d   = NUM_BITS'({shreg_q, ~shift_out});
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      CLK_HI: if (tick) state_d = (bit_cnt_q == CW'(NUM_BITS)) ? COMMIT : SAMPLE;
      default: begin
        state_d = LOAD;
        commit  = 1'b1;
      end
    endcase
  end

  assign commit_set = commit && (shreg_q == prev_q) && (shreg_q != buttons_q);
  assign rd_buttons = avs.avs_read  && (avs.avs_address == REG_BUTTONS);
  assign wr_status  = avs.avs_write && (avs.avs_address == REG_STATUS);
  assign ld_l       = avs.avs_write && (avs.avs_address == REG_DIAL_L);
  assign ld_r       = avs.avs_write && (avs.avs_address == REG_DIAL_R);

  always_comb begin
    changed_d = changed_q;
    if (commit_set) changed_d = 1'b1;
    else if (rd_buttons || (wr_status && avs.avs_writedata[STATUS_CHANGED]))
      changed_d = 1'b0;
    irq_en_d = wr_status ? avs.avs_writedata[STATUS_IRQ_EN] : irq_en_q;
  end

  always_comb begin
    rdata = '0;
    case (avs.avs_address)
      REG_BUTTONS: rdata = 32'(buttons_q);
      REG_DIAL_L:  rdata = {{24{cnt_l[7]}}, cnt_l};
      REG_DIAL_R:  rdata = {{24{cnt_r[7]}}, cnt_r};
      default: begin
        rdata[STATUS_CHANGED]                 = changed_q;
        rdata[STATUS_IRQ_EN]                  = irq_en_q;
        rdata[STATUS_CNT_LSB +: 16]           = scan_cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= LOAD;
      div_q         <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      prev_q        <= '0;
      buttons_q     <= '0;
      changed_q     <= 1'b0;
      irq_en_q      <= 1'b0;
      scan_cnt_q    <= '0;
      readdata_q    <= '0;
      irq_q         <= 1'b0;
      shift_load_q  <= 1'b1;
      shift_clkin_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      changed_q     <= changed_d;
      irq_en_q      <= irq_en_d;
      irq_q         <= changed_q && irq_en_q;
      shift_load_q  <= (state_d != LOAD);
      shift_clkin_q <= (state_d == CLK_HI);
      if (avs.avs_read) readdata_q <= rdata;
      if (commit) begin
        prev_q     <= shreg_q;
        scan_cnt_q <= scan_cnt_q + 16'd1;
        if (commit_set) buttons_q <= shreg_q;
      end
    end
  end

  quad_decoder u_dial_l (
    .clk          (clk),
    .reset_n      (reset_n),
    .ab_i         (dial_l),
    .load_i       (ld_l),
    .load_value_i (avs.avs_writedata[7:0]),
    .count_o      (cnt_l)
  );

  quad_decoder u_dial_r (
    .clk          (clk),
    .reset_n      (reset_n),
    .ab_i         (dial_r),
    .load_i       (ld_r),
    .load_value_i (avs.avs_writedata[7:0]),
    .count_o      (cnt_r)
  );

  assign unused_wdata     = ^avs.avs_writedata[31:8];
  assign avs.avs_readdata = readdata_q;
  assign irq              = irq_q;
  assign shift_load       = shift_load_q;
  assign shift_clkin      = shift_clkin_q;

endmodule

// File: tb/tb_display_input_scanner.sv
// Directed bench: reads push expected data into a scoreboard queue that a
// separate monitor pops when read data becomes valid.
module tb_display_input_scanner;
  import display_input_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int NB      = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       shift_clkin, shift_load, shift_out, irq;
  logic [1:0] dial_l = 2'b00;
  logic [1:0] dial_r = 2'b00;

  always #5 clk = ~clk;

  display_input_scanner_if bus ();

  display_input_scanner #(.CLK_DIV(CLK_DIV), .NUM_BITS(NB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .avs         (bus),
    .irq         (irq),
    .shift_clkin (shift_clkin),
    .shift_load  (shift_load),
    .shift_out   (shift_out),
    .dial_l      (dial_l),
    .dial_r      (dial_r)
  );

  // 74HC165-style chain: parallel load while low, shift on clkin rise.
  logic [7:0] pat = 8'h00;
  logic [7:0] sr  = 8'hFF;
  logic       clkin_prev = 1'b0;
  always @(posedge clk) begin
    clkin_prev <= shift_clkin;
    if (!shift_load) sr <= ~pat;
    else if (shift_clkin && !clkin_prev) sr <= {sr[6:0], 1'b1};
  end
  assign shift_out = sr[7];

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic rd_q = 1'b0;

  always @(posedge clk) rd_q <= bus.avs_read;

  always @(negedge clk) begin
    if (rd_q) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got=%h want=<none>", bus.avs_readdata);
      end else begin
        mon_e = sb.pop_front();
        if (bus.avs_readdata !== mon_e.exp) begin
          errors++;
          $display("FAIL %s got=%h want=%h", mon_e.nm, bus.avs_readdata, mon_e.exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    sb.push_back('{nm, exp});
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(posedge clk); #1;
    bus.avs_read    = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(posedge clk); #1;
    bus.avs_write     = 1'b0;
  endtask

  task automatic wait_sl(input logic v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (shift_load !== v && n < 500);
    if (shift_load !== v) begin
      checks++;
      errors++;
      $display("FAIL shift_load_wait got=%b want=%b", shift_load, v);
    end
  endtask

  task automatic next_load();
    wait_sl(1'b1);
    wait_sl(1'b0);
    wait_sl(1'b1);
  endtask

  task automatic step_l(input logic [1:0] v);
    @(posedge clk); #1;
    dial_l = v;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    bus.avs_address   = 2'd0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = 32'd0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_shift_load", 32'(shift_load), 32'd1);
    chk("rst_shift_clkin", 32'(shift_clkin), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_readdata", bus.avs_readdata, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_load", 32'(shift_load), 32'd0);
    rd(REG_BUTTONS, 32'd0, "rst_buttons");
    rd(REG_DIAL_L,  32'd0, "rst_dial_l");
    rd(REG_DIAL_R,  32'd0, "rst_dial_r");
    rd(REG_STATUS,  32'd0, "rst_status");

    // Buttons: A5 appears at the second COMMIT that sees it
    wr(REG_STATUS, 32'h2);
    pat = 8'hA5;
    next_load();
    next_load();
    next_load();
    rd(REG_STATUS, 32'h0003_0003, "status_changed");
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    rd(REG_BUTTONS, 32'h0000_00A5, "buttons_a5");
    repeat (2) @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'd0);
    rd(REG_STATUS, 32'h0003_0002, "status_cleared");

    // Debounce: one-scan glitch is rejected
    pat = 8'h3C;
    next_load();
    pat = 8'hA5;
    next_load();
    next_load();
    rd(REG_STATUS, 32'h0006_0002, "debounce_status");
    rd(REG_BUTTONS, 32'h0000_00A5, "debounce_buttons");

    // BUTTONS read in the very cycle COMMIT sets changed
    pat = 8'h0F;
    wait_sl(1'b1); wait_sl(1'b0);
    wait_sl(1'b1); wait_sl(1'b0);
    repeat (34) @(posedge clk);
    #1;
    sb.push_back('{"buttons_at_commit", 32'h0000_00A5});
    bus.avs_address = REG_BUTTONS;
    bus.avs_read    = 1'b1;
    @(posedge clk); #1;
    bus.avs_read    = 1'b0;
    rd(REG_STATUS, 32'h0009_0003, "changed_kept");
    @(negedge clk);
    chk("irq_kept", 32'(irq), 32'd1);
    rd(REG_BUTTONS, 32'h0000_000F, "buttons_0f");
    rd(REG_STATUS, 32'h0009_0002, "status_after_0f");

    // Dials
    step_l(2'b01); step_l(2'b11); step_l(2'b10); step_l(2'b00);
    rd(REG_DIAL_L, 32'd4, "dial_l_fwd4");
    step_l(2'b11); step_l(2'b00);
    rd(REG_DIAL_L, 32'd4, "dial_l_invalid");
    @(posedge clk); #1 dial_r = 2'b10;
    repeat (5) @(posedge clk);
    rd(REG_DIAL_R, 32'hFFFF_FFFF, "dial_r_back");
    wr(REG_DIAL_L, 32'd127);
    rd(REG_DIAL_L, 32'd127, "dial_l_load");
    step_l(2'b01);
    rd(REG_DIAL_L, 32'hFFFF_FF80, "dial_l_wrap");
    // Step reaches the counter 3 cycles after the edge; write lands there
    @(posedge clk); #1 dial_l = 2'b11;
    @(posedge clk);
    @(posedge clk); #1;
    bus.avs_address   = REG_DIAL_L;
    bus.avs_writedata = 32'h55;
    bus.avs_write     = 1'b1;
    @(posedge clk); #1;
    bus.avs_write     = 1'b0;
    repeat (3) @(posedge clk);
    rd(REG_DIAL_L, 32'h0000_0055, "dial_write_wins");
    @(posedge clk); #1;
    dial_l = 2'b00;
    dial_r = 2'b00;
    repeat (6) @(posedge clk);

    // Reset in the middle of a scan
    n = 0;
    while (shift_clkin !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("clk_hi_seen", 32'(shift_clkin), 32'd1);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_shift_load", 32'(shift_load), 32'd1);
    chk("midrst_shift_clkin", 32'(shift_clkin), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_load_first", 32'(shift_load), 32'd0);
    rd(REG_BUTTONS, 32'd0, "midrst_buttons");
    rd(REG_STATUS,  32'd0, "midrst_status");
    rd(REG_DIAL_R,  32'd0, "midrst_dial_r");

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
